// File: rtl/mfp_ahb_loader_arb_pkg.sv
// mfp_ahb_loader_arb_pkg: shared AHB encodings and arbiter state type
package mfp_ahb_loader_arb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  typedef enum logic [1:0] {
    ST_CPU     = 2'd0,
    ST_M1_ADDR = 2'd1,
    ST_M1_DATA = 2'd2
  } arb_state_t;
endpackage

// File: rtl/mfp_ahb_loader_arb_if.sv
// mfp_ahb_loader_arb_if: CPU, loader (M1) and slave-side signals of the loader arbiter
interface mfp_ahb_loader_arb_if;
  logic [31:0] CPU_HADDR;
  logic [1:0]  CPU_HTRANS;
  logic        CPU_HWRITE;
  logic [2:0]  CPU_HSIZE;
  logic [31:0] CPU_HWDATA;
  logic        CPU_HREADY;
  logic        CPU_HRESP;
  logic [31:0] CPU_HRDATA;
  logic        M1_REQ;
  logic [31:0] M1_ADDR;
  logic        M1_WRITE;
  logic [2:0]  M1_SIZE;
  logic [31:0] M1_WDATA;
  logic        M1_ACK;
  logic [31:0] M1_RDATA;
  logic        M1_ERR;
  logic [31:0] S_HADDR;
  logic [1:0]  S_HTRANS;
  logic        S_HWRITE;
  logic [2:0]  S_HSIZE;
  logic [31:0] S_HWDATA;
  logic        S_HREADY;
  logic        S_HRESP;
  logic [31:0] S_HRDATA;
  logic        M1_OWNS;
  modport master (
    input  CPU_HADDR, CPU_HTRANS, CPU_HWRITE, CPU_HSIZE, CPU_HWDATA,
    input  M1_REQ, M1_ADDR, M1_WRITE, M1_SIZE, M1_WDATA,
    input  S_HREADY, S_HRESP, S_HRDATA,
    output CPU_HREADY, CPU_HRESP, CPU_HRDATA,
    output M1_ACK, M1_RDATA, M1_ERR, M1_OWNS,
    output S_HADDR, S_HTRANS, S_HWRITE, S_HSIZE, S_HWDATA
  );
  modport slave (
    output CPU_HADDR, CPU_HTRANS, CPU_HWRITE, CPU_HSIZE, CPU_HWDATA,
    output M1_REQ, M1_ADDR, M1_WRITE, M1_SIZE, M1_WDATA,
    output S_HREADY, S_HRESP, S_HRDATA,
    input  CPU_HREADY, CPU_HRESP, CPU_HRDATA,
    input  M1_ACK, M1_RDATA, M1_ERR, M1_OWNS,
    input  S_HADDR, S_HTRANS, S_HWRITE, S_HSIZE, S_HWDATA
  );
endinterface

// File: rtl/mfp_ahb_loader_arb.sv
// mfp_ahb_loader_arb: shares the AHB-Lite slave path between the CPU and a single-beat loader master
module mfp_ahb_loader_arb
  import mfp_ahb_loader_arb_pkg::*;
#(
  parameter int GAP_CYCLES = 2
) (
  input logic                  HCLK,
  input logic                  HRESET,
  mfp_ahb_loader_arb_if.master bus
);
  localparam int GW = $clog2(GAP_CYCLES + 2);
  arb_state_t    state_q;
  logic [GW-1:0] gap_q;
  logic          ack_q;
  logic          err_q;
  logic [31:0]   rdata_q;
  logic          grant;
  logic          m1;
  // an IDLE CPU address phase with the slave ready means no CPU data phase can collide
  assign grant = bus.M1_REQ && !ack_q && gap_q == '0 && bus.S_HREADY && !bus.CPU_HTRANS[1];
  assign m1    = state_q != ST_CPU;
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= ST_CPU;
      gap_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q <= 1'b0;
      gap_q <= gap_q - GW'(gap_q != '0);
      case (state_q)
        ST_CPU:     if (grant) state_q <= ST_M1_ADDR;
        ST_M1_ADDR: if (bus.S_HREADY) state_q <= ST_M1_DATA;
        ST_M1_DATA: if (bus.S_HREADY) begin
          state_q <= ST_CPU;
          ack_q   <= 1'b1;
          err_q   <= bus.S_HRESP;
          rdata_q <= bus.S_HRDATA;
          gap_q   <= GW'(GAP_CYCLES);
        end
        default:    state_q <= ST_CPU;
      endcase
    end
  end
  assign bus.S_HADDR    = m1 ? bus.M1_ADDR : bus.CPU_HADDR;
  assign bus.S_HWRITE   = m1 ? bus.M1_WRITE : bus.CPU_HWRITE;
  assign bus.S_HSIZE    = m1 ? bus.M1_SIZE : bus.CPU_HSIZE;
  assign bus.S_HTRANS   = state_q == ST_M1_ADDR ? HTRANS_NONSEQ :
                          state_q == ST_M1_DATA ? HTRANS_IDLE : bus.CPU_HTRANS;
  assign bus.S_HWDATA   = state_q == ST_M1_DATA ? bus.M1_WDATA : bus.CPU_HWDATA;
  assign bus.CPU_HREADY = !m1 && bus.S_HREADY;
  assign bus.CPU_HRESP  = !m1 && bus.S_HRESP;
  assign bus.CPU_HRDATA = bus.S_HRDATA;
  assign bus.M1_ACK     = ack_q;
  assign bus.M1_ERR     = err_q;
  assign bus.M1_RDATA   = rdata_q;
  assign bus.M1_OWNS    = m1;
endmodule

// File: tb/tb_mfp_ahb_loader_arb.sv
// tb_mfp_ahb_loader_arb: directed and randomized checks of the loader arbiter against a cycle-level reference
module tb_mfp_ahb_loader_arb;
  import mfp_ahb_loader_arb_pkg::*;
  localparam int GAP = 2;
  logic HCLK;
  logic HRESET;
  mfp_ahb_loader_arb_if bus();
  mfp_ahb_loader_arb #(.GAP_CYCLES(GAP)) dut (.HCLK(HCLK), .HRESET(HRESET), .bus(bus));
  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end
  int n_cmp = 0;
  int n_err = 0;
  // reference: who owns the slave path (0 cpu, 1 loader address phase, 2 loader data phase)
  int          own = 0;
  int          since = 1000;
  logic        ack_m = 1'b0;
  logic        err_m = 1'b0;
  logic [31:0] rd_m = '0;
  logic        ack_s, hr_s, owns_s;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic model_update();
    logic done;
    done = 1'b0;
    if (HRESET) begin
      own = 0; ack_m = 1'b0; err_m = 1'b0; rd_m = '0; since = 1000;
    end else begin
      if (own == 0 && bus.M1_REQ && !ack_m && since >= GAP && bus.S_HREADY && !bus.CPU_HTRANS[1]) own = 1;
      else if (own == 1 && bus.S_HREADY) own = 2;
      else if (own == 2 && bus.S_HREADY) begin
        own = 0; done = 1'b1; rd_m = bus.S_HRDATA; err_m = bus.S_HRESP;
      end
      since = done ? 0 : (since < 1000 ? since + 1 : since);
      ack_m = done;
    end
  endtask
  task automatic cyc();
    @(negedge HCLK);
    chk("owns",   bus.M1_OWNS, 32'(own != 0));
    chk("htrans", bus.S_HTRANS, own == 1 ? HTRANS_NONSEQ : own == 2 ? HTRANS_IDLE : bus.CPU_HTRANS);
    chk("haddr",  bus.S_HADDR, own != 0 ? bus.M1_ADDR : bus.CPU_HADDR);
    chk("hwrite", bus.S_HWRITE, own != 0 ? bus.M1_WRITE : bus.CPU_HWRITE);
    chk("hsize",  bus.S_HSIZE, own != 0 ? bus.M1_SIZE : bus.CPU_HSIZE);
    chk("hwdata", bus.S_HWDATA, own == 2 ? bus.M1_WDATA : bus.CPU_HWDATA);
    chk("cpu_hready", bus.CPU_HREADY, own != 0 ? 1'b0 : bus.S_HREADY);
    chk("cpu_hresp",  bus.CPU_HRESP, own != 0 ? 1'b0 : bus.S_HRESP);
    chk("cpu_hrdata", bus.CPU_HRDATA, bus.S_HRDATA);
    chk("ack",   bus.M1_ACK, ack_m);
    chk("err",   bus.M1_ERR, err_m);
    chk("rdata", bus.M1_RDATA, rd_m);
    ack_s = bus.M1_ACK; hr_s = bus.CPU_HREADY; owns_s = bus.M1_OWNS;
    @(posedge HCLK);
    model_update();
    #1;
  endtask
  task automatic m1_xfer(input logic [31:0] a, input logic w, input logic [31:0] wd, input int waits,
                         input logic resp, input logic [31:0] rd, output int lat, output int stalls, output int own_at);
    int wl;
    wl = waits; lat = -1; stalls = 0; own_at = -1;
    bus.M1_REQ = 1'b1; bus.M1_ADDR = a; bus.M1_WRITE = w; bus.M1_SIZE = HSIZE_WORD; bus.M1_WDATA = wd;
    bus.CPU_HTRANS = HTRANS_IDLE; bus.S_HREADY = 1'b1; bus.S_HRESP = 1'b0;
    cyc();
    for (int k = 1; k <= 20; k++) begin
      bus.S_HREADY = !(own == 2 && wl > 0);
      if (own == 2 && wl > 0) wl--;
      bus.S_HRESP  = own == 2 ? resp : 1'b0;
      bus.S_HRDATA = own == 2 ? rd : $urandom;
      cyc();
      if (owns_s && own_at < 0) own_at = k;
      if (ack_s) begin lat = k; break; end
      if (!hr_s) stalls++;
    end
    bus.M1_REQ = 1'b0; bus.S_HREADY = 1'b1; bus.S_HRESP = 1'b0;
  endtask
  int lat, stalls, own_at, cnt;
  initial begin
    HRESET = 1'b1;
    bus.CPU_HADDR = 32'h1000_0004; bus.CPU_HTRANS = HTRANS_NONSEQ; bus.CPU_HWRITE = 1'b0;
    bus.CPU_HSIZE = HSIZE_WORD; bus.CPU_HWDATA = 32'hCAFE_0001;
    bus.M1_REQ = 1'b0; bus.M1_ADDR = '0; bus.M1_WRITE = 1'b0; bus.M1_SIZE = HSIZE_WORD; bus.M1_WDATA = '0;
    bus.S_HREADY = 1'b1; bus.S_HRESP = 1'b0; bus.S_HRDATA = 32'h5555_AAAA;
    @(posedge HCLK);
    model_update();
    #1;
    repeat (3) cyc();
    HRESET = 1'b0;
    m1_xfer(32'hBF80_0000, 1'b1, 32'h0000_ABCD, 0, 1'b0, 32'h0, lat, stalls, own_at);
    chk("wr_lat", lat, 3);
    chk("wr_stalls", stalls, 2);
    chk("wr_own_at", own_at, 1);
    repeat (3) cyc();
    m1_xfer(32'h0000_0100, 1'b0, 32'h0, 2, 1'b0, 32'h1234_5678, lat, stalls, own_at);
    chk("rd_lat", lat, 5);
    chk("rd_data", bus.M1_RDATA, 32'h1234_5678);
    chk("rd_err", bus.M1_ERR, 1'b0);
    repeat (3) cyc();
    bus.CPU_HTRANS = HTRANS_NONSEQ; bus.M1_REQ = 1'b1; bus.M1_ADDR = 32'h0000_0200; bus.M1_WRITE = 1'b0;
    cnt = 0;
    repeat (20) begin
      bus.CPU_HADDR = $urandom;
      cyc();
      if (owns_s) cnt++;
    end
    chk("starve_grants", cnt, 0);
    m1_xfer(32'h0000_0200, 1'b0, 32'h0, 0, 1'b0, 32'h0BAD_F00D, lat, stalls, own_at);
    chk("starve_own_at", own_at, 1);
    chk("starve_lat", lat, 3);
    m1_xfer(32'h0000_0204, 1'b1, 32'h0000_1111, 0, 1'b0, 32'h0, lat, stalls, own_at);
    chk("gap_own_at", own_at, 2);
    chk("gap_lat", lat, 4);
    repeat (3) cyc();
    m1_xfer(32'hBF80_0008, 1'b1, 32'hDEAD_BEEF, 1, 1'b1, 32'h0, lat, stalls, own_at);
    chk("err_lat", lat, 4);
    chk("err_flag", bus.M1_ERR, 1'b1);
    repeat (3) cyc();
    bus.M1_REQ = 1'b1; bus.M1_ADDR = 32'h0000_0300; bus.M1_WRITE = 1'b1; bus.M1_WDATA = 32'h7777_7777;
    cyc();
    cyc();
    chk("rst_in_data", bus.M1_OWNS, 1'b1);
    HRESET = 1'b1; bus.S_HREADY = 1'b0;
    cyc();
    HRESET = 1'b0; bus.M1_REQ = 1'b0; bus.S_HREADY = 1'b1;
    chk("rst_owns", bus.M1_OWNS, 1'b0);
    cnt = 0;
    repeat (4) begin
      cyc();
      if (ack_s) cnt++;
    end
    chk("rst_no_ack", cnt, 0);
    for (int i = 0; i < 4000; i++) begin
      HRESET = $urandom_range(0, 199) == 0;
      bus.CPU_HADDR = $urandom; bus.CPU_HWDATA = $urandom;
      bus.CPU_HTRANS = $urandom_range(0, 1) == 1 ? HTRANS_NONSEQ : HTRANS_IDLE;
      bus.CPU_HWRITE = 1'($urandom_range(0, 1)); bus.CPU_HSIZE = 3'($urandom_range(0, 2));
      bus.S_HREADY = $urandom_range(0, 3) != 0; bus.S_HRESP = $urandom_range(0, 7) == 0;
      bus.S_HRDATA = $urandom;
      if (!bus.M1_REQ || ack_m) begin
        bus.M1_REQ = $urandom_range(0, 2) != 0; bus.M1_ADDR = $urandom; bus.M1_WDATA = $urandom;
        bus.M1_WRITE = 1'($urandom_range(0, 1)); bus.M1_SIZE = 3'($urandom_range(0, 2));
      end
      cyc();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mfp_ahb_loader_arb.md
Name: mfp_ahb_loader_arb

Overview:
Shares the single AHB-Lite slave path (memory plus GPIO: switches, LEDs, push-buttons) between the MIPS core and a secondary loader/debug master, such as a UART program loader.
- The CPU owns the bus by default.
- The loader uses a simple req/ack interface. It gets one single-beat transfer only when the CPU address phase is IDLE.
- The CPU is stalled with CPU_HREADY low while the loader transfer is in progress.
- The block sits between the core's AHB master port and the AHB decoder/mux.

Parameters:
GAP_CYCLES, 2, minimum CPU-owned cycles after a loader ack before the loader can be granted again (0 is legal)

Ports:
HCLK  in  1  system clock
HRESET  in  1  reset, synchronous, active-high
CPU_HADDR  in  32  CPU address
CPU_HTRANS  in  2  CPU transfer type (IDLE/NONSEQ only)
CPU_HWRITE  in  1  CPU write
CPU_HSIZE  in  3  CPU size
CPU_HWDATA  in  32  CPU write data
CPU_HREADY  out  1  ready to CPU
CPU_HRESP  out  1  response to CPU
CPU_HRDATA  out  32  read data to CPU (S_HRDATA passthrough)
M1_REQ  in  1  loader request, level, held until ack
M1_ADDR  in  32  loader address, stable while REQ
M1_WRITE  in  1  loader write
M1_SIZE  in  3  loader size
M1_WDATA  in  32  loader write data
M1_ACK  out  1  one-cycle completion pulse
M1_RDATA  out  32  registered read data, valid with ACK
M1_ERR  out  1  registered S_HRESP, valid with ACK
S_HADDR  out  32  to slave
S_HTRANS  out  2  to slave
S_HWRITE  out  1  to slave
S_HSIZE  out  3  to slave
S_HWDATA  out  32  to slave
S_HREADY  in  1  from slave
S_HRESP  in  1  from slave
S_HRDATA  in  32  from slave
M1_OWNS  out  1  status: state is M1_ADDR or M1_DATA

Behaviour:
- FSM states: CPU, M1_ADDR, M1_DATA. Everything is registered on the HCLK rising edge.
- Reset state: CPU.
  - M1_ACK=0, M1_ERR=0, M1_RDATA=0, gap counter=0.
  - Outputs are combinational from the CPU state values.
- CPU state:
  - S_* = CPU_* passthrough; CPU_HREADY=S_HREADY; CPU_HRESP=S_HRESP.
- Grant: CPU -> M1_ADDR when all of the following hold:
  - M1_REQ=1 and M1_ACK=0;
  - gap=0;
  - S_HREADY=1;
  - CPU_HTRANS[1]=0.
  - These conditions guarantee no CPU data phase follows.
  - Otherwise remain in CPU. The CPU always wins a simultaneous request.
- M1_ADDR state:
  - S_HTRANS=NONSEQ; S_HADDR/S_HWRITE/S_HSIZE come from M1.
  - CPU_HREADY=0 and CPU_HRESP=0; the CPU holds its address phase.
  - Advance to M1_DATA when S_HREADY=1.
- M1_DATA state:
  - S_HTRANS=IDLE; S_HWDATA=M1_WDATA; CPU_HREADY=0.
  - When S_HREADY=1: register M1_RDATA=S_HRDATA and M1_ERR=S_HRESP, set M1_ACK=1 for one cycle, load gap=GAP_CYCLES, go to CPU.
- Gap counter: decrements by 1 per cycle while nonzero, saturating at 0.
- Latency with zero wait states:
  - REQ sampled at edge N.
  - M1_ADDR in cycle N+1, M1_DATA in cycle N+2.
  - ACK high in cycle N+3, which is the first CPU-state cycle.
- Wait states add one cycle each in M1_ADDR or M1_DATA.
- Slave ERROR response: do not retry. M1_ERR=1 with ACK. A two-cycle ERROR with HREADY low then high simply stays in M1_DATA until HREADY=1.
- S_HWDATA in the CPU state is always CPU_HWDATA. The CPU data phase never overlaps an M1 phase, by the grant rule.
- A CPU that never issues IDLE starves M1. This is accepted: the core issues IDLE regularly, and M1_OWNS/REQ are visible for debug.
- Reset mid-transfer: return to CPU next edge, no ACK issued. Slaves are reset by the same HRESET.
- M1 protocol rules: M1 must not change ADDR/WRITE/SIZE/WDATA while REQ=1 and ACK has not been seen. REQ sampled during the ACK cycle is ignored.

Decomposition:
- Shared package/header (mfp_ahb_const.vh): HTRANS_IDLE/NONSEQ encodings, FSM state encodings, HSIZE_WORD.
- No sub-module; the gap counter and FSM stay inline.

Test Plan:
- HRESET=1 for 3 cycles with CPU_HTRANS=NONSEQ -> M1_ACK=0, M1_OWNS=0, S_HADDR=CPU_HADDR, CPU_HREADY=S_HREADY.
- CPU idle, M1 write 0xBF800000 <= 0x0000ABCD (word), S_HREADY=1 -> S_HTRANS=NONSEQ at N+1, S_HWDATA=0x0000ABCD at N+2, ACK at N+3, CPU_HREADY=0 for exactly 2 cycles.
- M1 read 0x00000100 with the slave inserting 2 data-phase wait states and returning 0x12345678 -> ACK at N+5, M1_RDATA=0x12345678, M1_ERR=0.
- CPU NONSEQ every cycle for 20 cycles with M1_REQ high -> no grant. CPU drops to IDLE at cycle 21 -> M1_ADDR at cycle 22.
- GAP_CYCLES=2, M1_REQ re-asserted the cycle after ACK, CPU idle -> next M1_ADDR exactly 3 cycles after the ACK cycle.
- Slave returns HRESP=1 for an M1 write -> M1_ERR=1 with ACK. Separately, HRESET during M1_DATA -> state CPU next cycle, no ACK.
